// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
// Streams a DIM x DIM raster image through a two-row line buffer and a 3x3
// window register, emitting one 3x3 window per valid top-left position over
// a valid/ready handshake with a single output register.
// Optional build macro: CONV_SEQ_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles where a window is presented but not accepted.
module conv_window_sequencer #(
  parameter int DIM   = 28,
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [9*PIX_W-1:0]     win_data,
  output logic [$clog2(DIM)-1:0] win_row,
  output logic [$clog2(DIM)-1:0] win_col,
  output logic                   win_last,
  output logic                   busy,
  output logic                   done
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Pixel position counters and output register
  logic [CW-1:0]      row_r;
  logic [CW-1:0]      col_r;
  logic               win_valid_r;
  logic [9*PIX_W-1:0] win_data_r;
  logic [CW-1:0]      win_row_r;
  logic [CW-1:0]      win_col_r;
  logic               win_last_r;
  logic               busy_r;
  logic               done_r;

  // Line buffers (rows r-2 and r-1) and the sliding 3x3 window
  logic [PIX_W-1:0] lb_old_r [0:DIM-1];
  logic [PIX_W-1:0] lb_mid_r [0:DIM-1];
  logic [PIX_W-1:0] win_r      [0:2][0:2];
  logic [PIX_W-1:0] win_next_s [0:2][0:2];
  logic [9*PIX_W-1:0] win_pack_s;

  logic pix_ready_s;
  logic accept_s;
  logic load_s;
  logic last_pix_s;
  logic out_hs_s;
  logic start_go_s;

  // The source may only advance when the single output slot is free or draining.
  assign pix_ready_s = (state_r == STREAM) && (!win_valid_r || win_ready) && !abort;
  assign accept_s    = pix_valid && pix_ready_s;
  assign load_s      = accept_s && (row_r >= TWO) && (col_r >= TWO);
  assign last_pix_s  = accept_s && (row_r == LAST_IDX) && (col_r == LAST_IDX);
  assign out_hs_s    = win_valid_r && win_ready;
  assign start_go_s  = (state_r == IDLE) && start && !abort;

  assign pix_ready = pix_ready_s;
  assign win_valid = win_valid_r;
  assign win_data  = win_data_r;
  assign win_row   = win_row_r;
  assign win_col   = win_col_r;
  assign win_last  = win_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Window after shifting left one column and inserting the new right column.
  always_comb begin
    win_pack_s = {(9*PIX_W){1'b0}};
    for (int ky = 0; ky < 3; ky++) begin
      win_next_s[ky][0] = win_r[ky][1];
      win_next_s[ky][1] = win_r[ky][2];
    end
    win_next_s[0][2] = lb_old_r[col_r];
    win_next_s[1][2] = lb_mid_r[col_r];
    win_next_s[2][2] = pix_data;
    for (int k = 0; k < 9; k++) begin
      win_pack_s[PIX_W*k +: PIX_W] = win_next_s[k/3][k%3];
    end
  end

  // Next-state logic; abort overrides every state transition.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) state_next_s = STREAM;
          else       state_next_s = IDLE;
        end
        STREAM: begin
          if (last_pix_s) state_next_s = FLUSH;
          else            state_next_s = STREAM;
        end
        FLUSH: begin
          if (out_hs_s && win_last_r) state_next_s = DONE;
          else                        state_next_s = FLUSH;
        end
        DONE:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Position counters, window register and the single output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r       <= '0;
      col_r       <= '0;
      win_valid_r <= 1'b0;
      win_data_r  <= '0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      win_last_r  <= 1'b0;
      win_r       <= '{default: '0};
    end else if (abort || start_go_s) begin
      row_r       <= '0;
      col_r       <= '0;
      win_valid_r <= 1'b0;
      win_data_r  <= '0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      win_last_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        win_r <= win_next_s;
        if (col_r == LAST_IDX) begin
          col_r <= '0;
          row_r <= (row_r == LAST_IDX) ? '0 : row_r + CW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      if (load_s) begin
        win_valid_r <= 1'b1;
        win_data_r  <= win_pack_s;
        win_row_r   <= row_r - TWO;
        win_col_r   <= col_r - TWO;
        win_last_r  <= (row_r == LAST_IDX) && (col_r == LAST_IDX);
      end else if (out_hs_s) begin
        win_valid_r <= 1'b0;
        win_last_r  <= 1'b0;
      end
    end
  end

  // Line buffer update; contents are never cleared since every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_old_r[col_r] <= lb_mid_r[col_r];
      lb_mid_r[col_r] <= pix_data;
    end
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating count of stalled output cycles; survives abort, cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (start_go_s) begin
      stall_cnt_r <= 16'h0000;
    end else if (win_valid_r && !win_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a scoreboard of expected
// windows is filled as pixels are accepted and drained on output handshakes.
module tb_conv_window_sequencer;

  localparam int DIM   = 28;
  localparam int PIX_W = 8;
  localparam int CW    = $clog2(DIM);
  localparam int NWIN  = (DIM - 2) * (DIM - 2);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              win_valid;
  logic              win_ready;
  logic [9*PIX_W-1:0] win_data;
  logic [CW-1:0]     win_row;
  logic [CW-1:0]     win_col;
  logic              win_last;
  logic              busy;
  logic              done;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9*PIX_W-1:0] data;
    logic [CW-1:0]      row;
    logic [CW-1:0]      col;
    bit                 last;
  } win_t;

  win_t sb[$];

  always #5 clk = ~clk;

  conv_window_sequencer #(.DIM(DIM), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [PIX_W-1:0] img(input int r, input int c);
    return 8'((r * DIM + c) & 255);
  endfunction

  function automatic logic [9*PIX_W-1:0] exp_win(input int r0, input int c0);
    logic [9*PIX_W-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[PIX_W*k +: PIX_W] = img(r0 + k/3, c0 + k%3);
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
    pix_data = 8'h00; win_ready = 1'b0;
    #12;
    checks++;
    if ({pix_ready, win_valid, win_data, win_row, win_col, win_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%h/%0d/%0d/%b/%b/%b exp=all zero",
               pix_ready, win_valid, win_data, win_row, win_col, win_last, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle busy got=%b exp=0", busy);
    end
  endtask

  // Full frame with configurable output readiness period and pixel gap rate.
  task automatic test_frame(input string name, input int rdy_period, input int gap_pct);
    int ar = 0, ac = 0, nacc = 0, nwin = 0, cyc = 0;
    bit loaded = 0, hs_last = 0, hs_last_next = 0, stall_prev = 0, fin = 0;
    logic [9*PIX_W-1:0] pd = '0;
    logic [CW-1:0] prow = '0, pcol = '0;
    win_t e;
    sb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s start_busy got=%b exp=1", name, busy);
    end
    while (!fin && cyc < 20000) begin
      pix_valid = (nacc < DIM*DIM) && ($urandom_range(99) >= gap_pct);
      pix_data  = img(ar, ac);
      win_ready = (rdy_period <= 1) || ((cyc % rdy_period) == 0);
      #1;
      hs_last_next = 0;
      if (hs_last) begin
        checks++;
        if (done !== 1'b1) begin
          failures++; $display("FAIL %s done_pulse got=%b exp=1", name, done);
        end
        fin = 1;
      end else begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++; $display("FAIL %s busy_hold busy=%b done=%b exp=1/0 cyc=%0d", name, busy, done, cyc);
        end
      end
      if (stall_prev) begin
        checks++;
        if (win_valid !== 1'b1 || win_data !== pd || win_row !== prow || win_col !== pcol) begin
          failures++;
          $display("FAIL %s stall_stable got=%b/%h/%0d/%0d exp=1/%h/%0d/%0d",
                   name, win_valid, win_data, win_row, win_col, pd, prow, pcol);
        end
      end
      if (loaded) begin
        checks++;
        if (win_valid !== 1'b1 || win_data !== sb[$].data || win_row !== sb[$].row || win_col !== sb[$].col) begin
          failures++;
          $display("FAIL %s load_latency got=%b/%h/%0d/%0d exp=1/%h/%0d/%0d",
                   name, win_valid, win_data, win_row, win_col, sb[$].data, sb[$].row, sb[$].col);
        end
        if (sb[$].row == '0 && sb[$].col == '0) begin
          checks++;
          if (win_data !== 72'h3a3938_1e1d1c_020100) begin
            failures++;
            $display("FAIL %s first_window got=%h exp=3a39381e1d1c020100", name, win_data);
          end
        end
      end
      if (win_valid === 1'b1 && win_ready === 1'b0) begin
        checks++;
        if (pix_ready !== 1'b0) begin
          failures++; $display("FAIL %s bp_ready got=%b exp=0", name, pix_ready);
        end
      end
      loaded = 0;
      if (win_valid === 1'b1 && win_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL %s extra_window got=%0d/%0d exp=none", name, win_row, win_col);
        end else begin
          e = sb.pop_front();
          if (win_data !== e.data || win_row !== e.row || win_col !== e.col || win_last !== e.last) begin
            failures++;
            $display("FAIL %s window got=%h/%0d/%0d/%b exp=%h/%0d/%0d/%b",
                     name, win_data, win_row, win_col, win_last, e.data, e.row, e.col, e.last);
          end
          nwin++;
          if (e.last) hs_last_next = 1;
        end
      end
      if (pix_valid && pix_ready === 1'b1) begin
        if (ar >= 2 && ac >= 2) begin
          e.data = exp_win(ar - 2, ac - 2);
          e.row  = CW'(ar - 2);
          e.col  = CW'(ac - 2);
          e.last = (ar == DIM-1) && (ac == DIM-1);
          sb.push_back(e);
          loaded = 1;
        end
        nacc++;
        if (ac == DIM-1) begin ac = 0; ar++; end
        else ac++;
      end
      hs_last    = hs_last_next;
      stall_prev = (win_valid === 1'b1 && win_ready === 1'b0);
      pd = win_data; prow = win_row; pcol = win_col;
      cyc++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    checks++;
    if (fin !== 1'b1) begin
      failures++; $display("FAIL %s timeout got=%0d windows exp=%0d", name, nwin, NWIN);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done busy=%b done=%b exp=0/0", name, busy, done);
    end
    checks++;
    if (nwin != NWIN || sb.size() != 0) begin
      failures++; $display("FAIL %s window_count got=%0d left=%0d exp=%0d", name, nwin, sb.size(), NWIN);
    end
  endtask

  task automatic test_abort();
    int nacc = 0, cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    win_ready = 1'b1;
    while (nacc < 400 && cyc < 2000) begin
      pix_valid = 1'b1;
      pix_data  = 8'(nacc);
      #1;
      if (pix_ready === 1'b1) nacc++;
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || nacc != 400) begin
      failures++; $display("FAIL abort_pre busy=%b accepted=%0d exp=1/400", busy, nacc);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || pix_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_state busy=%b win_valid=%b pix_ready=%b done=%b exp=0/0/0/0",
               busy, win_valid, pix_ready, done);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL abort_no_done done=%b busy=%b exp=0/0", done, busy);
      end
    end
    test_frame("after_abort", 1, 0);
  endtask

`ifdef CONV_SEQ_STALL_CNT_EN
  task automatic test_stall_cnt();
    int cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL stall_start_clear got=%0d exp=0", stall_cnt);
    end
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'h55;
    #1;
    while (win_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    win_ready = 1'b1;
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++; $display("FAIL stall_count got=%0d exp=10", stall_cnt);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    win_ready = 1'b0;
    checks++;
    if (stall_cnt !== 16'd10) begin
      failures++; $display("FAIL stall_abort_keep got=%0d exp=10", stall_cnt);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL stall_restart_clear got=%0d exp=0", stall_cnt);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask
`endif

  task automatic test_async_rst();
    int cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'hA5;
    #1;
    while (win_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (win_valid !== 1'b1) begin
      failures++; $display("FAIL rst_setup win_valid got=%b exp=1", win_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({pix_ready, win_valid, win_data, win_row, win_col, win_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL async_rst got=%b/%b/%h/%0d/%0d/%b/%b/%b exp=all zero",
               pix_ready, win_valid, win_data, win_row, win_col, win_last, busy, done);
    end
    pix_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_start_ignored busy got=%b exp=0", busy);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_stays_idle busy got=%b exp=0", busy);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rst_new_start busy got=%b exp=1", busy);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame("full_frame", 1, 0);
    test_frame("backpressure", 3, 0);
    test_frame("pix_gaps", 1, 40);
    test_abort();
`ifdef CONV_SEQ_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
